// File: rtl/ft2232h_pkg.sv
// Shared types and constants for the FT2232H sync-245 receive path.
// Pin levels are named so active-low strobes read naturally.
package ft2232h_pkg;

  localparam int BYTE_W = 8;

  localparam logic PIN_ON  = 1'b0;
  localparam logic PIN_OFF = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    OE_ASSERT,
    READING,
    RELEASE
  } rx_state_e;

endpackage

// File: rtl/ft_rx_skid_fifo.sv
// First-word-fall-through skid buffer for captured bytes.
// rd_data holds the last popped byte while the buffer is empty.
module ft_rx_skid_fifo
  import ft2232h_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] rd_data,
  output logic              not_empty,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] FULL_LVL =
    (ADDR_W+1)'(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [BYTE_W-1:0] last_q;
  logic              full;
  logic              do_wr;
  logic              do_pop;

  assign full      = (count == FULL_LVL);
  assign not_empty = (count != '0);
  assign do_pop    = pop && not_empty;
  assign do_wr     = wr_en && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
        last_q <= mem[rd_ptr];
      end
      count <= count
             + (ADDR_W+1)'(do_wr)
             - (ADDR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = not_empty ? mem[rd_ptr] : last_q;

endmodule

// File: rtl/ft2232h_rx_reader.sv
// FT2232H sync-245 read controller: drives OE#/RD#, captures
// host bytes into a skid FIFO and streams them downstream.
module ft2232h_rx_reader
  import ft2232h_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rxf_n_i,
  input  logic [BYTE_W-1:0] data_i,
  output logic              oe_n_o,
  output logic              rd_n_o,
  output logic [BYTE_W-1:0] dout_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [15:0]       rx_count_o
);

  localparam logic [ADDR_W:0] FULL_LVL =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] START_LVL =
    (ADDR_W+1)'(DEPTH-2);

  rx_state_e       state;
  rx_state_e       state_nxt;
  logic            oe_n_nxt;
  logic            rd_n_nxt;
  logic            capture;
  logic            pop;
  logic [ADDR_W:0] fifo_count;
  logic [ADDR_W:0] count_nxt;

  assign capture = (rd_n_o == PIN_ON)
                && (rxf_n_i == PIN_ON);
  assign pop     = valid_o && ready_i;

  assign count_nxt = fifo_count
                   + (ADDR_W+1)'(capture)
                   - (ADDR_W+1)'(pop);

  ft_rx_skid_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .wr_en     (capture),
    .wr_data   (data_i),
    .pop       (pop),
    .rd_data   (dout_o),
    .not_empty (valid_o),
    .count     (fifo_count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      oe_n_o     <= PIN_OFF;
      rd_n_o     <= PIN_OFF;
      rx_count_o <= '0;
    end else begin
      state  <= state_nxt;
      oe_n_o <= oe_n_nxt;
      rd_n_o <= rd_n_nxt;
      if (capture) begin
        rx_count_o <= rx_count_o + 16'd1;
      end
    end
  end

  // Pin levels are decided here and registered, so the
  // chip never sees a combinational path from its own RXF#.
  always_comb begin
    state_nxt = state;
    oe_n_nxt  = PIN_OFF;
    rd_n_nxt  = PIN_OFF;
    unique case (state)
      IDLE: begin
        if (rxf_n_i == PIN_ON
            && count_nxt <= START_LVL) begin
          state_nxt = OE_ASSERT;
          oe_n_nxt  = PIN_ON;
        end
      end
      OE_ASSERT: begin
        if (rxf_n_i == PIN_OFF) begin
          state_nxt = RELEASE;
        end else begin
          state_nxt = READING;
          oe_n_nxt  = PIN_ON;
          rd_n_nxt  = PIN_ON;
        end
      end
      READING: begin
        if (rxf_n_i == PIN_OFF
            || count_nxt == FULL_LVL) begin
          state_nxt = RELEASE;
        end else begin
          oe_n_nxt = PIN_ON;
          rd_n_nxt = PIN_ON;
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ft2232h_rx_reader.sv
// Directed bench for ft2232h_rx_reader with a small FT2232H
// sync-245 chip model and an output stream monitor.
module tb_ft2232h_rx_reader;

  logic        clk;
  logic        rst_i;
  logic        rxf_n_i;
  logic [7:0]  data_i;
  logic        oe_n_o;
  logic        rd_n_o;
  logic [7:0]  dout_o;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] rx_count_o;

  int tests_run;
  int tests_failed;

  logic [7:0] chip_mem [64];
  logic [5:0] chip_rd;
  logic [5:0] chip_wr;
  logic       gap;
  logic [7:0] got [$];
  bit         ovf;

  ft2232h_rx_reader dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .rxf_n_i    (rxf_n_i),
    .data_i     (data_i),
    .oe_n_o     (oe_n_o),
    .rd_n_o     (rd_n_o),
    .dout_o     (dout_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .rx_count_o (rx_count_o)
  );

  initial clk = 1'b0;
  always #8 clk = ~clk;

  assign rxf_n_i = (chip_rd == chip_wr) || gap;
  assign data_i  = chip_mem[chip_rd];

  // Chip pops a byte on every edge that sees RD# and RXF# low.
  always @(posedge clk) begin
    if (!rd_n_o && !rxf_n_i) chip_rd <= chip_rd + 6'd1;
  end

  always @(negedge clk) begin
    if (!rst_i && valid_o && ready_i) got.push_back(dout_o);
    if (!rst_i && !rd_n_o && !rxf_n_i
        && dut.fifo_count == 3'd4
        && !(valid_o && ready_i)) ovf = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bytes(input logic [7:0] base,
                            input int n);
    for (int i = 0; i < n; i++) begin
      chip_mem[chip_wr] = base + 8'(i);
      chip_wr = chip_wr + 6'd1;
    end
  endtask

  task automatic wait_got(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (got.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    int idx;
    bit ok;
    idx = got.size();
    ready_i = 1'b1;
    push_bytes(8'h5A, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if ({oe_n_o, rd_n_o, valid_o} !== 3'b110
          || rx_count_o !== 16'd0) begin
        tests_failed++;
        $display("FAIL reset_hold[%0d] oe=%b rd=%b v=%b cnt=%0d want 1 1 0 0",
                 i, oe_n_o, rd_n_o, valid_o, rx_count_o);
      end
    end
    rst_i = 1'b0;
    tick();
    tests_run++;
    if (oe_n_o !== 1'b0 || rd_n_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release oe=%b rd=%b want 0 1",
               oe_n_o, rd_n_o);
    end
    wait_got(idx + 1, ok);
    tests_run++;
    if (!ok || got[idx] !== 8'h5A) begin
      tests_failed++;
      $display("FAIL reset_first_byte ok=%0d want 5a", ok);
    end
  endtask

  task automatic test_single();
    int idx;
    do_reset();
    idx = got.size();
    ready_i = 1'b1;
    push_bytes(8'hA5, 1);
    tick();
    tests_run++;
    if (oe_n_o !== 1'b0 || rd_n_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_oe oe=%b rd=%b want 0 1",
               oe_n_o, rd_n_o);
    end
    tick();
    tests_run++;
    if (oe_n_o !== 1'b0 || rd_n_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_rd oe=%b rd=%b want 0 0",
               oe_n_o, rd_n_o);
    end
    tick();
    tests_run++;
    if (valid_o !== 1'b1 || dout_o !== 8'hA5) begin
      tests_failed++;
      $display("FAIL single_data v=%b d=%h want 1 a5",
               valid_o, dout_o);
    end
    tick();
    tests_run++;
    if ({oe_n_o, rd_n_o, valid_o} !== 3'b110
        || dout_o !== 8'hA5) begin
      tests_failed++;
      $display("FAIL single_release oe=%b rd=%b v=%b d=%h want 1 1 0 a5",
               oe_n_o, rd_n_o, valid_o, dout_o);
    end
    tick();
    tests_run++;
    if ({oe_n_o, rd_n_o} !== 2'b11 || rx_count_o !== 16'd1
        || got.size() != idx + 1 || got[idx] !== 8'hA5) begin
      tests_failed++;
      $display("FAIL single_idle oe=%b rd=%b cnt=%0d n=%0d want 1 1 1 1",
               oe_n_o, rd_n_o, rx_count_o, got.size() - idx);
    end
  endtask

  task automatic test_burst();
    int idx;
    int bad;
    do_reset();
    idx = got.size();
    ready_i = 1'b1;
    push_bytes(8'h00, 16);
    tick();
    tick();
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (rd_n_o !== 1'b0 || rxf_n_i !== 1'b0) begin
        tests_failed++;
        $display("FAIL burst_rd[%0d] rd=%b rxf=%b want 0 0",
                 i, rd_n_o, rxf_n_i);
      end
      tick();
      tests_run++;
      if (valid_o !== 1'b1 || dout_o !== 8'(i)) begin
        tests_failed++;
        $display("FAIL burst_out[%0d] v=%b d=%h want 1 %h",
                 i, valid_o, dout_o, 8'(i));
      end
    end
    tick();
    tests_run++;
    if (rd_n_o !== 1'b1 || valid_o !== 1'b0
        || rx_count_o !== 16'd16) begin
      tests_failed++;
      $display("FAIL burst_end rd=%b v=%b cnt=%0d want 1 0 16",
               rd_n_o, valid_o, rx_count_o);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (got.size() <= idx + i || got[idx+i] !== 8'(i)) bad++;
    end
    tests_run++;
    if (bad != 0 || got.size() != idx + 16) begin
      tests_failed++;
      $display("FAIL burst_order bad=%0d n=%0d want 0 16",
               bad, got.size() - idx);
    end
  endtask

  task automatic test_backpressure();
    int idx;
    int bad;
    bit ok;
    do_reset();
    idx = got.size();
    ready_i = 1'b0;
    push_bytes(8'h20, 10);
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (rd_n_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_rd[%0d] rd=%b want 0", k, rd_n_o);
      end
      tick();
    end
    tests_run++;
    if (rd_n_o !== 1'b1 || valid_o !== 1'b1
        || dout_o !== 8'h20 || rx_count_o !== 16'd4) begin
      tests_failed++;
      $display("FAIL bp_full rd=%b v=%b d=%h cnt=%0d want 1 1 20 4",
               rd_n_o, valid_o, dout_o, rx_count_o);
    end
    tick();
    tick();
    tick();
    tests_run++;
    if ({oe_n_o, rd_n_o} !== 2'b11 || rx_count_o !== 16'd4) begin
      tests_failed++;
      $display("FAIL bp_stall oe=%b rd=%b cnt=%0d want 1 1 4",
               oe_n_o, rd_n_o, rx_count_o);
    end
    ready_i = 1'b1;
    wait_got(idx + 10, ok);
    tick();
    tick();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (got.size() <= idx + i
          || got[idx+i] !== 8'h20 + 8'(i)) bad++;
    end
    tests_run++;
    if (!ok || bad != 0 || got.size() != idx + 10
        || rx_count_o !== 16'd10) begin
      tests_failed++;
      $display("FAIL bp_drain ok=%0d bad=%0d n=%0d cnt=%0d want 1 0 10 10",
               ok, bad, got.size() - idx, rx_count_o);
    end
    tests_run++;
    if (ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_overflow seen=%b want 0", ovf);
    end
  endtask

  task automatic test_rxf_gap();
    int idx;
    int bad;
    bit ok;
    do_reset();
    idx = got.size();
    ready_i = 1'b1;
    push_bytes(8'h40, 8);
    tick();
    tick();
    tick();
    tick();
    tick();
    gap = 1'b1;
    tick();
    tests_run++;
    if ({oe_n_o, rd_n_o} !== 2'b11 || rx_count_o !== 16'd3) begin
      tests_failed++;
      $display("FAIL gap_release oe=%b rd=%b cnt=%0d want 1 1 3",
               oe_n_o, rd_n_o, rx_count_o);
    end
    tick();
    tick();
    tests_run++;
    if (oe_n_o !== 1'b1 || rx_count_o !== 16'd3) begin
      tests_failed++;
      $display("FAIL gap_hold oe=%b cnt=%0d want 1 3",
               oe_n_o, rx_count_o);
    end
    gap = 1'b0;
    tick();
    tests_run++;
    if (oe_n_o !== 1'b0 || rd_n_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL gap_restart oe=%b rd=%b want 0 1",
               oe_n_o, rd_n_o);
    end
    wait_got(idx + 8, ok);
    tick();
    tick();
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (got.size() <= idx + i
          || got[idx+i] !== 8'h40 + 8'(i)) bad++;
    end
    tests_run++;
    if (!ok || bad != 0 || rx_count_o !== 16'd8) begin
      tests_failed++;
      $display("FAIL gap_order ok=%0d bad=%0d cnt=%0d want 1 0 8",
               ok, bad, rx_count_o);
    end
  endtask

  task automatic test_reset_mid();
    int idx;
    int bad;
    bit ok;
    do_reset();
    idx = got.size();
    ready_i = 1'b1;
    push_bytes(8'h60, 8);
    for (int i = 0; i < 5; i++) tick();
    rst_i = 1'b1;
    tick();
    tests_run++;
    if ({oe_n_o, rd_n_o, valid_o} !== 3'b110
        || rx_count_o !== 16'd0) begin
      tests_failed++;
      $display("FAIL midrst_pins oe=%b rd=%b v=%b cnt=%0d want 1 1 0 0",
               oe_n_o, rd_n_o, valid_o, rx_count_o);
    end
    tests_run++;
    if (got.size() != idx + 2 || got[idx] !== 8'h60
        || got[idx+1] !== 8'h61) begin
      tests_failed++;
      $display("FAIL midrst_pre n=%0d want 2 (60 61)",
               got.size() - idx);
    end
    rst_i = 1'b0;
    idx = got.size();
    wait_got(idx + 4, ok);
    tick();
    tick();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (got.size() <= idx + i
          || got[idx+i] !== 8'h64 + 8'(i)) bad++;
    end
    tests_run++;
    if (!ok || bad != 0 || got.size() != idx + 4
        || rx_count_o !== 16'd4) begin
      tests_failed++;
      $display("FAIL midrst_resume ok=%0d bad=%0d cnt=%0d want 1 0 4",
               ok, bad, rx_count_o);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    chip_rd      = '0;
    chip_wr      = '0;
    gap          = 1'b0;
    ovf          = 1'b0;
    rst_i        = 1'b1;
    ready_i      = 1'b0;
    for (int i = 0; i < 64; i++) chip_mem[i] = 8'h00;
    tick();
    tick();
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_rxf_gap();
    test_reset_mid();
    tests_run++;
    if (ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL overflow_any seen=%b want 0", ovf);
    end
    $display("[TB] %0d tests run, %0d failed",
             tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
